// File: rtl/bw_defs.sv
// Shared definitions for the Baugh-Wooley multipliers: controller state
// encodings and the partial-product row generator.
package bw_defs;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    // Rows are produced at a fixed maximum width; callers keep the low m bits.
    localparam int PP_MAXW = 64;
    localparam int PP_IW   = $clog2(PP_MAXW);

    // Row i of the modified Baugh-Wooley array for m-bit operands: the sign
    // column of ordinary rows and the ordinary columns of the sign row are
    // inverted, while the sign x sign corner stays true.
    function automatic logic [PP_MAXW-1:0] pp_row(
        input logic [PP_MAXW-1:0] a,
        input logic [PP_MAXW-1:0] b,
        input int unsigned        i,
        input int unsigned        m
    );
        logic [PP_MAXW-1:0] row;
        logic               bit_ij;
        row = '0;
        for (int unsigned j = 0; j < PP_MAXW; j++) begin
            bit_ij = 1'b0;
            if (j < m) begin
                bit_ij = a[j[PP_IW-1:0]] & b[i[PP_IW-1:0]];
                if ((j == m - 1) != (i == m - 1)) begin
                    bit_ij = ~bit_ij;
                end
            end
            row[j[PP_IW-1:0]] = bit_ij;
        end
        return row;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the carry-save layer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/layer_adder.sv
// One carry-save row: adds a new partial-product row to the running sum
// shifted down one column, retiring the lowest sum bit as p.
module layer_adder #(
    parameter int M = 5
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic [M-2:0] c_in,
    output logic [M-1:0] s,
    output logic [M-2:0] c_out,
    output logic         p
);

    assign p      = a[0];
    assign s[M-1] = b[M-1];

    for (genvar j = 0; j < M - 1; j++) begin : g_fa
        full_adder u_fa (
            .a (a[j+1]),
            .b (b[j]),
            .ci(c_in[j]),
            .s (s[j]),
            .co(c_out[j])
        );
    end

endmodule

// File: rtl/bw_seq_mult.sv
// Sequential signed MxM Baugh-Wooley multiplier: one carry-save layer reused
// per clock, then a single carry-propagate merge with the correction ones.
module bw_seq_mult
    import bw_defs::*;
#(
    parameter int M = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*M-1:0] product,
    output logic [1:0]     dbg_state
);

    localparam int            CW       = $clog2(M);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
    localparam logic [M-1:0]  CORR     = M'(1) | (M'(1) << (M - 1));

    logic [1:0]     state_q, state_d;
    logic [M-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic [M-1:0]   sum_q, sum_d;
    logic [M-2:0]   carry_q, carry_d;
    logic [M-2:0]   low_q, low_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*M-1:0] product_q, product_d;
    logic           done_q, done_d;

    logic [PP_MAXW-1:0] row0_full;
    logic [PP_MAXW-1:0] rowk_full;
    logic [M-1:0]       la_s;
    logic [M-2:0]       la_c;
    logic               la_p;
    logic [M-1:0]       hi;
    logic               unused_row_bits;

    assign row0_full = pp_row(PP_MAXW'(a), PP_MAXW'(b), 0, M);
    assign rowk_full = pp_row(PP_MAXW'(a_q), PP_MAXW'(b_q), 32'(cnt_q), M);
    assign unused_row_bits = ^{row0_full[PP_MAXW-1:M], rowk_full[PP_MAXW-1:M]};

    layer_adder #(.M(M)) u_layer (
        .a    (sum_q),
        .b    (rowk_full[M-1:0]),
        .c_in (carry_q),
        .s    (la_s),
        .c_out(la_c),
        .p    (la_p)
    );

    // Upper half: remaining sum and carry vectors plus the ones at columns M and 2M-1.
    assign hi = {1'b0, sum_q[M-1:1]} + {1'b0, carry_q} + CORR;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        low_d     = low_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = row0_full[M-1:0];
                    carry_d = '0;
                    cnt_d   = CW'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Retired bits enter from the top so the first one lands in bit 0.
                low_d   = {la_p, low_q[M-2:1]};
                sum_d   = la_s;
                carry_d = la_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                product_d = {hi, sum_q[0], low_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            low_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            low_q     <= low_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == ACCUM) || (state_q == FINAL);
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bw_seq_mult.sv
// Bench for bw_seq_mult: directed corners, exhaustive back-to-back M=5,
// ignored start, async reset mid-operation, and an M=3/4/8 sweep.
module tb_bw_seq_mult;

    localparam int M = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [M-1:0]   a;
    logic [M-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*M-1:0] product;
    logic [1:0]     dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    bit sweep_go = 1'b0;
    int sweep_left = 3;

    logic [2*M-1:0] exp_q[$];

    always #5 clk = ~clk;

    bw_seq_mult #(.M(M)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[2*M-1:0];
    endfunction

    // Issue one operation (called at a point away from the clock edge) and
    // follow it to its done pulse; optionally pulse start again at E2.
    task automatic op(input logic [M-1:0] ai, input logic [M-1:0] bi, input bit poke, input string tag);
        int             e;
        int             bcnt;
        logic [2*M-1:0] expv;
        exp_q.push_back(ref_mul(ai, bi));
        a = ai;
        b = bi;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = M'($urandom);
        b = M'($urandom);
        check({tag, "_done_after_accept"}, 64'(done), 64'(0));
        bcnt = int'(busy);
        e = 0;
        while (!done && e < 4 * M) begin
            if (poke && e == 1) begin
                start = 1'b1;
                a = M'($urandom);
                b = M'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            e++;
            if (!done) bcnt += int'(busy);
        end
        expv = exp_q.pop_front();
        check({tag, "_latency"}, 64'(e), 64'(M));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(M));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_product"}, 64'(product), 64'(expv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        op(5'd15, 5'd15, 1'b0, "dir_15x15");
        check("dir_15x15_value", 64'(product), 64'h0E1);
        op(5'h10, 5'h10, 1'b0, "dir_min_min");
        check("dir_min_min_value", 64'(product), 64'h100);
        op(5'h01F, 5'h1F, 1'b0, "dir_m1_m1");
        check("dir_m1_m1_value", 64'(product), 64'h001);
        op(5'd0, 5'h19, 1'b0, "dir_0_m7");
        check("dir_0_m7_value", 64'(product), 64'h000);
        op(5'h10, 5'd15, 1'b0, "dir_min_max");
        check("dir_min_max_value", 64'(product), 64'h310);

        // A second start at E2 plus operand changes after E0 must not matter.
        op(5'd9, 5'h1A, 1'b1, "ignore_start");
        @(posedge clk); #1;
        check("ignore_no_extra_done", 64'(done), 64'(0));
        check("ignore_idle_busy", 64'(busy), 64'(0));

        // Asynchronous reset mid-ACCUM discards the operation at once.
        a = 5'd11;
        b = 5'd13;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_product", 64'(product), 64'(0));
        check("midrst_state", 64'(dbg_state), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", 64'(done), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        op(5'd11, 5'd13, 1'b0, "after_reset");

        // Exhaustive, back-to-back: each start lands in the previous done cycle.
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
                op(x[M-1:0], y[M-1:0], 1'b0, "exh");
            end
        end

        for (int r = 0; r < 20; r++) begin
            op(M'($urandom_range(0, 31)), M'($urandom_range(0, 31)), r[0], "rand");
        end

        @(negedge clk);
        sweep_go = 1'b1;
        wait (sweep_left == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int MW = (g == 0) ? 3 : ((g == 1) ? 4 : 8);

        logic            s_start;
        logic [MW-1:0]   s_a;
        logic [MW-1:0]   s_b;
        logic            s_busy;
        logic            s_done;
        logic [2*MW-1:0] s_product;
        logic [1:0]      s_state;

        bw_seq_mult #(.M(MW)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (s_start),
            .a        (s_a),
            .b        (s_b),
            .busy     (s_busy),
            .done     (s_done),
            .product  (s_product),
            .dbg_state(s_state)
        );

        initial begin
            int              e;
            longint          p;
            logic [MW-1:0]   mn;
            logic [MW-1:0]   mx;
            logic [MW-1:0]   xa;
            logic [MW-1:0]   xb;
            logic [2*MW-1:0] expv;
            s_start = 1'b0;
            s_a = '0;
            s_b = '0;
            mn = MW'(1) << (MW - 1);
            mx = mn - MW'(1);
            wait (sweep_go);
            for (int t = 0; t < 15; t++) begin
                case (t)
                    0:       begin xa = mn; xb = mn; end
                    1:       begin xa = mn; xb = mx; end
                    2:       begin xa = mx; xb = mx; end
                    default: begin xa = MW'($urandom); xb = MW'($urandom); end
                endcase
                p = longint'($signed(xa)) * longint'($signed(xb));
                expv = p[2*MW-1:0];
                s_a = xa;
                s_b = xb;
                s_start = 1'b1;
                @(posedge clk); #1;
                s_start = 1'b0;
                s_a = MW'($urandom);
                s_b = MW'($urandom);
                e = 0;
                while (!s_done && e < 4 * MW) begin
                    @(posedge clk); #1;
                    e++;
                end
                check($sformatf("sweep_m%0d_latency", MW), 64'(e), 64'(MW));
                check($sformatf("sweep_m%0d_product", MW), 64'(s_product), 64'(expv));
            end
            sweep_left--;
        end
    end

endmodule
